pcileech_tlps128_cfg_requester: RTL and testbench

PCILEECH_TLPS128_CFG_REQUESTER -- requirements
Module: pcileech_tlps128_cfg_requester

---
 rtl/pcileech_cfg_pkg.sv | 36 +++
 rtl/pcileech_tlps128_cpl_decode.sv | 34 +++
 rtl/pcileech_tlps128_cfg_requester.sv | 171 +++++++++++++++++
 tb/tb_pcileech_tlps128_cfg_requester.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcileech_cfg_pkg.sv
// Shared constants for the 128-bit config-space requester: TLP fmt/type bytes,
// completion status codes, response status encoding and the requester FSM states.
package pcileech_cfg_pkg;

    localparam logic [7:0] FMT_CFGRD0 = 8'h04;
    localparam logic [7:0] FMT_CFGWR0 = 8'h44;
    localparam logic [7:0] FMT_CPL    = 8'h0A;
    localparam logic [7:0] FMT_CPLD   = 8'h4A;

    localparam logic [2:0] CPL_STATUS_SC = 3'b000;
    localparam logic [2:0] CPL_STATUS_UR = 3'b001;

    localparam logic [1:0] RSP_SC      = 2'b00;
    localparam logic [1:0] RSP_UR      = 2'b01;
    localparam logic [1:0] RSP_ERR     = 2'b10;
    localparam logic [1:0] RSP_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_CPL,
        ST_RESP
    } cfg_state_t;

    // CA, CRS and reserved completion codes all collapse onto RSP_ERR
    function automatic logic [1:0] map_cpl_status(input logic [2:0] cpl_status);
        logic [1:0] s;
        case (cpl_status)
            CPL_STATUS_SC: s = RSP_SC;
            CPL_STATUS_UR: s = RSP_UR;
            default:       s = RSP_ERR;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/pcileech_tlps128_cpl_decode.sv
// Combinational completion header matcher/decoder for the single outstanding
// config request identified by (pcie_id, tag).
module pcileech_tlps128_cpl_decode
    import pcileech_cfg_pkg::*;
(
    input  logic [127:0] rx_tdata,
    input  logic [8:0]   rx_tuser,
    input  logic         rx_tvalid,
    input  logic [15:0]  pcie_id,
    input  logic [7:0]   tag,
    output logic         match,
    output logic [1:0]   status,
    output logic [31:0]  data
);

    logic [7:0] fmt_type;
    logic [2:0] cpl_status;
    logic       is_cpl;

    assign fmt_type   = rx_tdata[31:24];
    assign cpl_status = rx_tdata[47:45];
    assign is_cpl     = (fmt_type == FMT_CPL) || (fmt_type == FMT_CPLD);

    assign match = rx_tvalid && rx_tuser[0] && is_cpl &&
                   (rx_tdata[95:80] == pcie_id) && (rx_tdata[79:72] == tag);

    assign status = map_cpl_status(cpl_status);
    assign data   = ((fmt_type == FMT_CPLD) && (cpl_status == CPL_STATUS_SC)) ?
                    rx_tdata[127:96] : 32'h0;

    logic unused_bits;
    assign unused_bits = ^{rx_tuser[8:1], rx_tdata[71:48], rx_tdata[44:32], rx_tdata[23:0]};

endmodule

// File: rtl/pcileech_tlps128_cfg_requester.sv
// Type-0 config read/write requester: one request in flight, single-beat 128-bit
// TLP out, matching completion (or timeout) returned on the rsp_* handshake.
module pcileech_tlps128_cfg_requester
    import pcileech_cfg_pkg::*;
#(
    parameter logic [31:0] CPL_TIMEOUT = 32'd50000
)
(
    input  logic         clk_pcie,
    input  logic         rst,
    input  logic [15:0]  pcie_id,

    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic         cmd_wr,
    input  logic [15:0]  cmd_target,
    input  logic [9:0]   cmd_addr,
    input  logic [3:0]   cmd_be,
    input  logic [31:0]  cmd_wdata,

    output logic [127:0] tx_tdata,
    output logic [3:0]   tx_tkeepdw,
    output logic         tx_tlast,
    output logic [8:0]   tx_tuser,
    output logic         tx_valid,
    input  logic         tx_ready,

    input  logic [127:0] rx_tdata,
    input  logic [8:0]   rx_tuser,
    input  logic         rx_tvalid,

    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [31:0]  rsp_data,
    output logic [1:0]   rsp_status,
    output logic [7:0]   rsp_tag
);

    cfg_state_t   state, next_state;
    logic [7:0]   tag_cnt;
    logic [31:0]  timer;
    logic         timer_expired;

    logic         req_wr;
    logic [15:0]  req_target;
    logic [9:0]   req_addr;
    logic [3:0]   req_be;
    logic [31:0]  req_wdata;
    logic [7:0]   req_tag;

    logic         cpl_match;
    logic [1:0]   cpl_status;
    logic [31:0]  cpl_data;
    logic [127:0] tlp;

    pcileech_tlps128_cpl_decode u_cpl_decode (
        .rx_tdata  (rx_tdata),
        .rx_tuser  (rx_tuser),
        .rx_tvalid (rx_tvalid),
        .pcie_id   (pcie_id),
        .tag       (req_tag),
        .match     (cpl_match),
        .status    (cpl_status),
        .data      (cpl_data)
    );

    assign timer_expired = (timer == CPL_TIMEOUT - 32'd1);

    always_ff @(posedge clk_pcie) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Handshake outputs are gated by rst so they read inactive during reset
    // regardless of the registered state.
    always_comb begin
        next_state = state;
        cmd_ready  = 1'b0;
        tx_valid   = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) next_state = ST_SEND;
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                if (tx_ready) next_state = ST_WAIT_CPL;
            end
            ST_WAIT_CPL: begin
                if (cpl_match || timer_expired) next_state = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) next_state = ST_IDLE;
            end
            default: next_state = ST_IDLE;
        endcase
        if (rst) begin
            next_state = ST_IDLE;
            cmd_ready  = 1'b0;
            tx_valid   = 1'b0;
            rsp_valid  = 1'b0;
        end
    end

    always_ff @(posedge clk_pcie) begin
        if (rst) begin
            tag_cnt    <= '0;
            timer      <= '0;
            req_wr     <= 1'b0;
            req_target <= '0;
            req_addr   <= '0;
            req_be     <= '0;
            req_wdata  <= '0;
            req_tag    <= '0;
            rsp_data   <= '0;
            rsp_status <= '0;
            rsp_tag    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        req_wr     <= cmd_wr;
                        req_target <= cmd_target;
                        req_addr   <= cmd_addr;
                        req_be     <= cmd_be;
                        req_wdata  <= cmd_wdata;
                        req_tag    <= tag_cnt;
                        tag_cnt    <= tag_cnt + 8'd1;
                    end
                end
                ST_SEND: begin
                    if (tx_ready) timer <= '0;
                end
                ST_WAIT_CPL: begin
                    timer <= timer + 32'd1;
                    // a completion landing on the expiry cycle still wins
                    if (cpl_match) begin
                        rsp_status <= cpl_status;
                        rsp_data   <= cpl_data;
                        rsp_tag    <= req_tag;
                    end else if (timer_expired) begin
                        rsp_status <= RSP_TIMEOUT;
                        rsp_data   <= 32'hFFFF_FFFF;
                        rsp_tag    <= req_tag;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        tlp            = '0;
        tlp[31:24]     = req_wr ? FMT_CFGWR0 : FMT_CFGRD0;
        tlp[9:0]       = 10'd1;
        tlp[63:32]     = {pcie_id, req_tag, 4'h0, req_be};
        tlp[95:64]     = {req_target, 4'h0, req_addr, 2'b00};
        tlp[127:96]    = req_wr ? req_wdata : 32'h0;
    end

    assign tx_tdata   = tx_valid ? tlp : '0;
    assign tx_tkeepdw = tx_valid ? (req_wr ? 4'b1111 : 4'b0111) : 4'b0000;
    assign tx_tlast   = tx_valid;
    assign tx_tuser   = '0;

endmodule

// File: tb/tb_pcileech_tlps128_cfg_requester.sv
// Self-checking bench for the config requester: transaction-level model with a
// per-cycle compare process, directed scenarios and a randomized 257-request run.
module tb_pcileech_tlps128_cfg_requester;

    localparam logic [31:0] TO      = 32'd100;
    localparam logic [15:0] PCIE_ID = 16'hA5C3;

    typedef struct {
        logic        wr;
        logic [15:0] target;
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [7:0]  tag;
    } req_t;

    logic         clk_pcie = 1'b0;
    logic         rst;
    logic [15:0]  pcie_id;
    logic         cmd_valid, cmd_ready, cmd_wr;
    logic [15:0]  cmd_target;
    logic [9:0]   cmd_addr;
    logic [3:0]   cmd_be;
    logic [31:0]  cmd_wdata;
    logic [127:0] tx_tdata;
    logic [3:0]   tx_tkeepdw;
    logic         tx_tlast;
    logic [8:0]   tx_tuser;
    logic         tx_valid, tx_ready;
    logic [127:0] rx_tdata;
    logic [8:0]   rx_tuser;
    logic         rx_tvalid;
    logic         rsp_valid, rsp_ready;
    logic [31:0]  rsp_data;
    logic [1:0]   rsp_status;
    logic [7:0]   rsp_tag;

    pcileech_tlps128_cfg_requester #(.CPL_TIMEOUT(TO)) dut (
        .clk_pcie   (clk_pcie),
        .rst        (rst),
        .pcie_id    (pcie_id),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_wr     (cmd_wr),
        .cmd_target (cmd_target),
        .cmd_addr   (cmd_addr),
        .cmd_be     (cmd_be),
        .cmd_wdata  (cmd_wdata),
        .tx_tdata   (tx_tdata),
        .tx_tkeepdw (tx_tkeepdw),
        .tx_tlast   (tx_tlast),
        .tx_tuser   (tx_tuser),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_tdata   (rx_tdata),
        .rx_tuser   (rx_tuser),
        .rx_tvalid  (rx_tvalid),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_status (rsp_status),
        .rsp_tag    (rsp_tag)
    );

    always #5 clk_pcie = ~clk_pcie;

    int   n_checks = 0;
    int   n_fail   = 0;

    // transaction-level model state
    req_t        cur;
    logic [7:0]  model_tag;
    logic        busy, tx_pending, rsp_pending;
    logic [1:0]  exp_status;
    logic [31:0] exp_data;
    logic [7:0]  exp_tag;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] model_tlp(input req_t r);
        logic [31:0] dw0, dw1, dw2, dw3;
        dw0 = r.wr ? 32'h4400_0001 : 32'h0400_0001;
        dw1 = {PCIE_ID, r.tag, 4'h0, r.be};
        dw2 = {r.target, 4'h0, r.addr, 2'b00};
        dw3 = r.wr ? r.wdata : 32'h0;
        return {dw3, dw2, dw1, dw0};
    endfunction

    function automatic logic [127:0] make_cpl(input logic [7:0] fmt, input logic [15:0] id,
                                              input logic [7:0] tag, input logic [2:0] st,
                                              input logic [31:0] data);
        return {data, id, tag, 1'b0, 7'h00, 16'hBEEF, st, 1'b0, 12'd4, fmt, 14'h0, 10'd1};
    endfunction

    function automatic logic [1:0] model_status(input logic [2:0] st);
        if (st == 3'd0) return 2'd0;
        if (st == 3'd1) return 2'd1;
        return 2'd2;
    endfunction

    // per-cycle comparison of every handshake output against the model
    always @(posedge clk_pcie) begin
        #2;
        if (!rst) begin
            chk("cmd_ready", 128'(cmd_ready), 128'(!busy));
            chk("tx_valid", 128'(tx_valid), 128'(tx_pending));
            chk("rsp_valid", 128'(rsp_valid), 128'(rsp_pending));
            if (tx_pending) begin
                chk("tx_tdata", tx_tdata, model_tlp(cur));
                chk("tx_tkeepdw", 128'(tx_tkeepdw), cur.wr ? 128'hF : 128'h7);
                chk("tx_tlast", 128'(tx_tlast), 128'd1);
                chk("tx_tuser", 128'(tx_tuser), 128'd0);
            end
            if (rsp_pending) begin
                chk("rsp_data", 128'(rsp_data), 128'(exp_data));
                chk("rsp_status", 128'(rsp_status), 128'(exp_status));
                chk("rsp_tag", 128'(rsp_tag), 128'(exp_tag));
            end
        end
    end

    task automatic issue_cmd(input logic wr, input logic [15:0] target, input logic [9:0] addr,
                             input logic [3:0] be, input logic [31:0] wdata);
        @(negedge clk_pcie);
        cmd_valid  = 1'b1;
        cmd_wr     = wr;
        cmd_target = target;
        cmd_addr   = addr;
        cmd_be     = be;
        cmd_wdata  = wdata;
        @(posedge clk_pcie);
        #1;
        cmd_valid  = 1'b0;
        cmd_wdata  = $urandom;
        cmd_target = 16'($urandom);
        cur = '{wr: wr, target: target, addr: addr, be: be, wdata: wdata, tag: model_tag};
        model_tag  = model_tag + 8'd1;
        busy       = 1'b1;
        tx_pending = 1'b1;
    endtask

    task automatic tx_handshake(input int unsigned hold);
        repeat (hold) @(negedge clk_pcie);
        @(negedge clk_pcie);
        tx_ready = 1'b1;
        @(posedge clk_pcie);
        #1;
        tx_ready   = 1'b0;
        tx_pending = 1'b0;
    endtask

    task automatic send_cpl(input logic [7:0] fmt, input logic [15:0] id, input logic [7:0] tag,
                            input logic [2:0] st, input logic [31:0] data, input logic sof);
        logic m;
        @(negedge clk_pcie);
        rx_tdata  = make_cpl(fmt, id, tag, st, data);
        rx_tuser  = {8'($urandom), sof};
        rx_tvalid = 1'b1;
        m = sof && (fmt == 8'h0A || fmt == 8'h4A) && (id == PCIE_ID) && (tag == cur.tag) &&
            busy && !tx_pending && !rsp_pending;
        @(posedge clk_pcie);
        #1;
        rx_tvalid = 1'b0;
        rx_tdata  = {4{32'($urandom)}};
        if (m) begin
            rsp_pending = 1'b1;
            exp_status  = model_status(st);
            exp_data    = (fmt == 8'h4A && st == 3'd0) ? data : 32'h0;
            exp_tag     = cur.tag;
        end
    endtask

    task automatic rsp_accept(input int unsigned hold);
        repeat (hold) @(negedge clk_pcie);
        @(negedge clk_pcie);
        rsp_ready = 1'b1;
        @(posedge clk_pcie);
        #1;
        rsp_ready   = 1'b0;
        rsp_pending = 1'b0;
        busy        = 1'b0;
    endtask

    task automatic check_reset_values(input string tagname);
        chk({tagname, "_cmd_ready"}, 128'(cmd_ready), 128'd0);
        chk({tagname, "_tx_valid"}, 128'(tx_valid), 128'd0);
        chk({tagname, "_rsp_valid"}, 128'(rsp_valid), 128'd0);
        chk({tagname, "_tx_tdata"}, tx_tdata, 128'd0);
        chk({tagname, "_rsp_data"}, 128'(rsp_data), 128'd0);
        chk({tagname, "_rsp_status"}, 128'(rsp_status), 128'd0);
        chk({tagname, "_rsp_tag"}, 128'(rsp_tag), 128'd0);
    endtask

    logic [2:0] st_tab [4] = '{3'd0, 3'd1, 3'd2, 3'd4};

    initial begin
        rst = 1'b1; pcie_id = PCIE_ID;
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_target = '0; cmd_addr = '0; cmd_be = '0; cmd_wdata = '0;
        tx_ready = 1'b0; rx_tdata = '0; rx_tuser = '0; rx_tvalid = 1'b0; rsp_ready = 1'b0;
        busy = 1'b0; tx_pending = 1'b0; rsp_pending = 1'b0; model_tag = 8'h00;
        cur = '{wr: 1'b0, target: 16'h0, addr: 10'h0, be: 4'h0, wdata: 32'h0, tag: 8'h0};
        exp_status = 2'd0; exp_data = 32'h0; exp_tag = 8'h0;

        repeat (3) @(posedge clk_pcie);
        #2;
        check_reset_values("init_rst");
        @(negedge clk_pcie);
        rst = 1'b0;
        @(posedge clk_pcie);
        #2;
        chk("post_rst_cmd_ready", 128'(cmd_ready), 128'd1);

        // config read, CplD SC
        issue_cmd(1'b0, 16'h0100, 10'd0, 4'hF, 32'h0);
        #1;
        chk("rd_fmt", 128'(tx_tdata[31:24]), 128'h04);
        chk("rd_keep", 128'(tx_tkeepdw), 128'h7);
        chk("rd_tag", 128'(tx_tdata[47:40]), 128'h00);
        tx_handshake(0);
        send_cpl(8'h4A, PCIE_ID, 8'h00, 3'd0, 32'h8086201D, 1'b1);
        #1;
        chk("rd_rsp_data", 128'(rsp_data), 128'h8086201D);
        chk("rd_rsp_status", 128'(rsp_status), 128'h0);
        rsp_accept(0);

        // config write, Cpl SC
        issue_cmd(1'b1, 16'h0100, 10'd4, 4'hF, 32'hFEBF0000);
        #1;
        chk("wr_fmt", 128'(tx_tdata[31:24]), 128'h44);
        chk("wr_dw2_addr", 128'(tx_tdata[75:66]), 128'd4);
        chk("wr_dw3", 128'(tx_tdata[127:96]), 128'hFEBF0000);
        chk("wr_keep", 128'(tx_tkeepdw), 128'hF);
        tx_handshake(1);
        send_cpl(8'h0A, PCIE_ID, 8'h01, 3'd0, 32'hDEADBEEF, 1'b1);
        #1;
        chk("wr_rsp_data", 128'(rsp_data), 128'h0);
        chk("wr_rsp_status", 128'(rsp_status), 128'h0);
        rsp_accept(0);

        // wrong tag, wrong requester ID, then matching UR
        issue_cmd(1'b0, 16'h0208, 10'd1, 4'hF, 32'h0);
        tx_handshake(0);
        send_cpl(8'h4A, PCIE_ID, 8'h03, 3'd0, 32'h11111111, 1'b1);
        send_cpl(8'h4A, 16'hA5C2, 8'h02, 3'd0, 32'h22222222, 1'b1);
        send_cpl(8'h0A, PCIE_ID, 8'h02, 3'd1, 32'h33333333, 1'b1);
        #1;
        chk("ur_rsp_status", 128'(rsp_status), 128'h1);
        chk("ur_rsp_tag", 128'(rsp_tag), 128'h02);
        chk("ur_rsp_data", 128'(rsp_data), 128'h0);
        rsp_accept(0);

        // tx_ready and rsp_ready held low for 5 cycles: outputs must stay put
        issue_cmd(1'b1, 16'h0310, 10'h3FF, 4'h5, 32'hCAFEF00D);
        tx_handshake(5);
        send_cpl(8'h4A, PCIE_ID, 8'h03, 3'd2, 32'h44444444, 1'b1);
        rsp_accept(5);

        // no completion: timeout exactly TO cycles after the tx handshake
        issue_cmd(1'b0, 16'h0100, 10'd2, 4'hF, 32'h0);
        tx_handshake(0);
        for (int unsigned n = 1; n <= TO; n++) begin
            @(posedge clk_pcie);
            #1;
            if (n == TO) begin
                rsp_pending = 1'b1;
                exp_status  = 2'd3;
                exp_data    = 32'hFFFFFFFF;
                exp_tag     = cur.tag;
            end
        end
        #1;
        chk("to_rsp_status", 128'(rsp_status), 128'h3);
        chk("to_rsp_data", 128'(rsp_data), 128'hFFFFFFFF);
        send_cpl(8'h4A, PCIE_ID, 8'h04, 3'd0, 32'h55555555, 1'b1);
        rsp_accept(2);
        send_cpl(8'h4A, PCIE_ID, 8'h04, 3'd0, 32'h66666666, 1'b1);
        repeat (3) @(posedge clk_pcie);

        // reset while waiting for a completion
        issue_cmd(1'b0, 16'h0400, 10'd8, 4'hF, 32'h0);
        tx_handshake(0);
        repeat (3) @(negedge clk_pcie);
        rst = 1'b1;
        busy = 1'b0; tx_pending = 1'b0; rsp_pending = 1'b0; model_tag = 8'h00;
        @(posedge clk_pcie);
        #2;
        check_reset_values("mid_rst");
        repeat (2) @(negedge clk_pcie);
        rst = 1'b0;
        @(posedge clk_pcie);
        #2;
        chk("mid_rst_cmd_ready", 128'(cmd_ready), 128'd1);
        send_cpl(8'h4A, PCIE_ID, 8'h05, 3'd0, 32'h77777777, 1'b1);
        repeat (5) @(posedge clk_pcie);

        // 257 randomized back-to-back requests: tags 00..FF then 00
        for (int unsigned i = 0; i < 257; i++) begin
            int unsigned njunk;
            issue_cmd(1'($urandom), 16'($urandom), 10'($urandom), 4'($urandom), $urandom);
            #1;
            chk("tag_seq", 128'(tx_tdata[47:40]), 128'(i % 256));
            tx_handshake($urandom_range(0, 3));
            njunk = $urandom_range(0, 2);
            for (int unsigned j = 0; j < njunk; j++) begin
                repeat ($urandom_range(0, 3)) @(negedge clk_pcie);
                case ($urandom_range(0, 3))
                    0: send_cpl(8'h4A, PCIE_ID, cur.tag ^ 8'($urandom_range(1, 255)), 3'd0, $urandom, 1'b1);
                    1: send_cpl(8'h4A, PCIE_ID ^ 16'($urandom_range(1, 65535)), cur.tag, 3'd0, $urandom, 1'b1);
                    2: send_cpl(8'h4A, PCIE_ID, cur.tag, 3'd0, $urandom, 1'b0);
                    default: send_cpl(8'h04, PCIE_ID, cur.tag, 3'd0, $urandom, 1'b1);
                endcase
            end
            send_cpl($urandom_range(0, 1) ? 8'h4A : 8'h0A, PCIE_ID, cur.tag,
                     st_tab[$urandom_range(0, 3)], $urandom, 1'b1);
            rsp_accept($urandom_range(0, 3));
        end

        repeat (3) @(posedge clk_pcie);
        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
